// File: rtl/cevero_vreg_seq.sv
// Regulator-side voltage sequencer.
// Walks the regulator code one level at a time toward the clamped request,
// holding each level for SETTLE_CYCLES edges. Timing-error pulses are masked
// while a transition is in flight and tallied in a saturating counter.
module cevero_vreg_seq #(
   parameter int LEVEL_W       = 3,
   parameter int SETTLE_CYCLES = 16,
   parameter int RESET_LEVEL   = 5,
   parameter int MIN_LEVEL     = 1,
   parameter int MAX_LEVEL     = 7,
   parameter int MCNT_W        = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [LEVEL_W-1:0] set_voltage_i,
   input  logic               error_i,
   output logic               error_o,
   output logic [LEVEL_W-1:0] vreg_code_o,
   output logic [LEVEL_W-1:0] cur_voltage_o,
   output logic               settled_o,
   output logic               busy_o,
   output logic               step_o,
   output logic               clamp_o,
   output logic [MCNT_W-1:0]  masked_cnt_o
);

   // Settle counter only needs to hold SETTLE_CYCLES-1; keep at least one bit.
   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0]   CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [LEVEL_W-1:0] MIN_L      = LEVEL_W'(MIN_LEVEL);
   localparam logic [LEVEL_W-1:0] MAX_L      = LEVEL_W'(MAX_LEVEL);
   localparam logic [LEVEL_W-1:0] RESET_L    = LEVEL_W'(RESET_LEVEL);

   // Reject parameter sets that would let the level leave the legal window.
   generate
      if (RESET_LEVEL < MIN_LEVEL || RESET_LEVEL > MAX_LEVEL) begin : g_bad_reset_level
         $error("cevero_vreg_seq: RESET_LEVEL outside [MIN_LEVEL, MAX_LEVEL]");
      end
      if (MIN_LEVEL > MAX_LEVEL) begin : g_bad_window
         $error("cevero_vreg_seq: MIN_LEVEL greater than MAX_LEVEL");
      end
      if (SETTLE_CYCLES < 1) begin : g_bad_settle
         $error("cevero_vreg_seq: SETTLE_CYCLES must be at least 1");
      end
   endgenerate

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      SETTLE = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [LEVEL_W-1:0] cur_q, cur_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               step_q, step_d;
   logic               settled_q, settled_d;
   logic               clamp_q, clamp_d;
   logic [MCNT_W-1:0]  masked_cnt_q, masked_cnt_d;

   logic [LEVEL_W-1:0] tgt;
   logic               req_low;
   logic               req_high;
   logic               do_step;

   // Clamp the raw request into the legal window; compare one bit wider so a
   // window edge at the code-space limit is still a meaningful comparison.
   always_comb begin
      req_low  = ({1'b0, set_voltage_i} < {1'b0, MIN_L});
      req_high = ({1'b0, set_voltage_i} > {1'b0, MAX_L});
      tgt      = set_voltage_i;
      if (req_low) begin
         tgt = MIN_L;
      end else if (req_high) begin
         tgt = MAX_L;
      end
   end

   // Next-state logic: decide whether to take a one-level step this edge.
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      cnt_d   = cnt_q;
      step_d  = 1'b0;
      do_step = 1'b0;

      case (state_q)
         IDLE: begin
            if (tgt != cur_q) begin
               do_step = 1'b1;
            end
         end
         SETTLE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (tgt != cur_q) begin
               do_step = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A step always moves exactly one level toward the current target.
      if (do_step) begin
         if (tgt > cur_q) begin
            cur_d = cur_q + LEVEL_W'(1);
         end else begin
            cur_d = cur_q - LEVEL_W'(1);
         end
         step_d  = 1'b1;
         cnt_d   = CNT_RELOAD;
         state_d = SETTLE;
      end
   end

   // Status and masked-error bookkeeping derived for the next edge.
   always_comb begin
      settled_d    = (state_d == IDLE);
      clamp_d      = req_low | req_high;
      masked_cnt_d = masked_cnt_q;
      if (error_i && !settled_q && (masked_cnt_q != '1)) begin
         masked_cnt_d = masked_cnt_q + MCNT_W'(1);
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         cur_q        <= RESET_L;
         cnt_q        <= '0;
         step_q       <= 1'b0;
         settled_q    <= 1'b1;
         clamp_q      <= 1'b0;
         masked_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         cur_q        <= cur_d;
         cnt_q        <= cnt_d;
         step_q       <= step_d;
         settled_q    <= settled_d;
         clamp_q      <= clamp_d;
         masked_cnt_q <= masked_cnt_d;
      end
   end

   assign vreg_code_o   = cur_q;
   assign cur_voltage_o = cur_q;
   assign settled_o     = settled_q;
   assign busy_o        = ~settled_q;
   assign step_o        = step_q;
   assign clamp_o       = clamp_q;
   assign masked_cnt_o  = masked_cnt_q;
   assign error_o       = error_i & settled_q;

endmodule
